// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: phase encodings, sequencer states, counter width
package cpu_pkg;

  localparam logic [2:0] PH_IDLE = 3'b000;
  localparam logic [2:0] PH_P1   = 3'b001;
  localparam logic [2:0] PH_P2   = 3'b010;
  localparam logic [2:0] PH_P3   = 3'b011;
  localparam logic [2:0] PH_P4   = 3'b100;
  localparam logic [2:0] PH_P5   = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } seq_state_t;

  localparam int RETIRED_W = 16;

  // P5 wraps back to P1; instruction boundaries are handled by the caller.
  function automatic logic [2:0] next_phase(input logic [2:0] ph);
    return (ph == PH_P5) ? PH_P1 : ph + 3'd1;
  endfunction

endpackage

// File: rtl/phase_gen_if.sv
// rtl/phase_gen_if.sv - phase sequencer bus; step_mode exists only with PHASE_STEP_EN
interface phase_gen_if;
  import cpu_pkg::*;

  logic                 start_btn;
  logic                 stop_btn;
  logic                 hlt;
`ifdef PHASE_STEP_EN
  logic                 step_mode;
`endif
  logic [2:0]           phase;
  logic                 running;
  logic                 halted;
  logic [RETIRED_W-1:0] retired;

`ifdef PHASE_STEP_EN
  modport master (
    input  start_btn, stop_btn, hlt, step_mode,
    output phase, running, halted, retired
  );
  modport slave (
    output start_btn, stop_btn, hlt, step_mode,
    input  phase, running, halted, retired
  );
`else
  modport master (
    input  start_btn, stop_btn, hlt,
    output phase, running, halted, retired
  );
  modport slave (
    output start_btn, stop_btn, hlt,
    input  phase, running, halted, retired
  );
`endif

endinterface

// File: rtl/btn_sync.sv
// rtl/btn_sync.sv - two-flop button synchronizer with one-cycle rising-edge pulse
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  // Pulse is decoded from flops only, so it is glitch-free inside the clock domain.
  assign pulse = sync2 & ~sync2_d;

endmodule

// File: rtl/phase_gen.sv
// rtl/phase_gen.sv - five-phase instruction sequencer with run/stop/halt control
// Optional single-instruction stepping is built when PHASE_STEP_EN is defined.
module phase_gen
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  phase_gen_if.master bus
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_HALT = ST_HALT;

  logic start_p;
  logic stop_p;
  logic step_stop;

  logic [1:0]           state_q, state_d;
  logic [2:0]           phase_q, phase_d;
  logic                 stop_req_q, stop_req_d;
  logic [RETIRED_W-1:0] retired_q, retired_d;
  logic                 running_q, halted_q;
  logic                 eoi;

  btn_sync u_start_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.start_btn),
    .pulse (start_p)
  );

  btn_sync u_stop_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.stop_btn),
    .pulse (stop_p)
  );

`ifdef PHASE_STEP_EN
  assign step_stop = bus.step_mode;
`else
  assign step_stop = 1'b0;
`endif

  assign eoi = (state_q == S_RUN) && (phase_q == PH_P5);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    stop_req_d = stop_req_q;
    retired_d  = retired_q;

    case (state_q)
      S_IDLE: begin
        // A simultaneous stop press cancels the start.
        if (start_p && !stop_p) begin
          state_d = S_RUN;
          phase_d = PH_P1;
        end
      end

      S_RUN: begin
        if (eoi) begin
          retired_d = retired_q + 1'b1;
          if (bus.hlt) begin
            state_d    = S_HALT;
            phase_d    = PH_IDLE;
            stop_req_d = 1'b0;
          end else if (stop_req_q || stop_p || step_stop) begin
            state_d    = S_IDLE;
            phase_d    = PH_IDLE;
            stop_req_d = 1'b0;
          end else begin
            phase_d = next_phase(phase_q);
          end
        end else begin
          phase_d = next_phase(phase_q);
          if (stop_p) begin
            stop_req_d = 1'b1;
          end
        end
      end

      S_HALT: begin
        phase_d = PH_IDLE;
      end

      default: begin
        state_d    = S_IDLE;
        phase_d    = PH_IDLE;
        stop_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_IDLE;
      stop_req_q <= 1'b0;
      retired_q  <= '0;
      running_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      stop_req_q <= stop_req_d;
      retired_q  <= retired_d;
      running_q  <= (state_d == S_RUN);
      halted_q   <= (state_d == S_HALT);
    end
  end

  assign bus.phase   = phase_q;
  assign bus.running = running_q;
  assign bus.halted  = halted_q;
  assign bus.retired = retired_q;

endmodule
